mem_wb_stage: RTL and testbench
===============================

// Module: mem_wb_stage
// PURPOSE
//  Parametrised successor to the combinational writeback stage: owns the MEM/WB pipeline register and
//  a 4-way result select (adds CSR read data). It also performs load byte/half extraction with sign/zero
//  extension and suppresses writes to x0. It additionally flags misaligned loads and keeps a retired-
//  instruction counter. Sits between the memory stage and the register file / hazard unit.
// PARAMETERS
//  ADDRESS_WIDTH  32  width of pc_plus4
//  DATA_WIDTH     32  datapath width (must be 32; byte lanes fixed at 4)
//  CNT_WIDTH      64  width of instret counter
// PORTS
//  clk                input   1              rising-edge clock
//  rst                input   1              asynchronous, active-high reset
//  stall_w            input   1              hold MEM/WB register
//  flush_w            input   1              load a bubble into MEM/WB register
//  valid_m            input   1              MEM stage holds a real instruction
//  reg_write_m        input   1              instruction writes rd
//  result_src_m       input   2              00 ALU, 01 load, 10 pc+4, 11 CSR
//  funct3_m           input   3              load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
//  alu_result_m       input   DATA_WIDTH     ALU result / load address
//  read_data_m        input   DATA_WIDTH     raw aligned word from data memory
//  csr_rdata_m        input   DATA_WIDTH     CSR read value
//  pc_plus4_m         input   ADDRESS_WIDTH  link value
//  rd_m               input   5              destination register
//  result_w           output  DATA_WIDTH     value to register file / forwarding
//  reg_write_w        output  1              register-file write enable
//  rd_w               output  5              destination register
//  valid_w            output  1              WB holds a real instruction
//  load_misaligned_w  output  1              misaligned load in WB (exception request)
//  instret            output  CNT_WIDTH      retired-instruction count
// BEHAVIOUR
//  - Reset (async, rst=1): all MEM/WB fields 0, so valid_w=0, reg_write_w=0, rd_w=0, result_w=0,
//    load_misaligned_w=0, instret=0. Deassertion takes effect at the next rising edge.
//  - Capture at posedge clk, priority: flush_w > stall_w > load.
//    - flush_w=1: valid and reg_write fields cleared (bubble); other fields don't-care.
//    - stall_w=1 and flush_w=0: all fields hold.
//    - otherwise: all *_m inputs are registered.
//  - Latency: one cycle from MEM inputs to WB outputs. All outputs are combinational from the
//    registered fields only; no input feeds an output combinationally.
//  - Load extract: offset = alu_result[1:0] (registered).
//    - LB/LBU: byte at lane offset.
//    - LH/LHU: half at lane offset[1].
//    - LW: full word.
//    - Sign- or zero-extended per funct3. Unknown funct3 yields a full word.
//  - Misaligned: (LH/LHU and offset[0]=1) or (LW and offset!=0), only when result_src=01 and valid.
//    When set, load_misaligned_w=1 and reg_write_w is forced 0.
//  - reg_write_w = valid & reg_write & (rd!=0) & !misaligned.
//  - result_w follows result_src even when reg_write_w=0.
//  - instret increments by 1 on each posedge where valid_w=1 and stall_w=0 (the instruction leaves WB).
//    - A misaligned load does not count.
//    - A concurrent flush_w does not block the count (flush acts on the incoming instruction only).
//    - instret wraps modulo 2^CNT_WIDTH.
//  - Reset mid-stall or mid-flush: reset wins; the stage comes up empty.
// STRUCTURE
//  - Shared package wb_pkg holds:
//    - RES_ALU/RES_LOAD/RES_PC4/RES_CSR encodings (2 bits).
//    - F3_LB/LH/LW/LBU/LHU constants.
//  - Sub-module load_ext (purely combinational): in word, offset[1:0], funct3 -> out data, misaligned.
//  - Top level contains the MEM/WB register, result select and instret counter.
// TESTING
//  1. rst=1 mid-run with valid_m=1 -> all outputs 0 immediately (before any clock edge), instret=0.
//  2. read_data_m=32'h80F1_7F22, alu_result_m=32'h1003, LB -> result_w=32'hFFFF_FF80;
//     same word with LBU and offset 2 -> 32'h0000_00F1; LH with offset 2 -> 32'hFFFF_80F1.
//  3. LW at alu_result_m=32'h1002 -> load_misaligned_w=1, reg_write_w=0, instret unchanged.
//  4. reg_write_m=1, rd_m=0, ALU=5 -> result_w=5, reg_write_w=0.
//     Then rd_m=3 -> reg_write_w=1, rd_w=3.
//  5. Stall 3 cycles with a valid JAL in WB:
//     - result_w=pc_plus4 (32'h104) held throughout;
//     - instret +1 exactly once, on the first unstalled edge.
//  6. flush_w=1 and stall_w=1 together -> bubble loaded (valid_w=0, reg_write_w=0).
//     instret preloaded to 2^CNT_WIDTH-1 then one retire -> 0.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared encodings for the MEM/WB writeback stage.
// Result-select codes and load funct3 values.
package wb_pkg;

    localparam logic [1:0] RES_ALU  = 2'b00;
    localparam logic [1:0] RES_LOAD = 2'b01;
    localparam logic [1:0] RES_PC4  = 2'b10;
    localparam logic [1:0] RES_CSR  = 2'b11;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_ext.sv
// Load lane extraction with sign/zero extension.
// Also reports natural-alignment violations.
module load_ext
    import wb_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  offset_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o,
    output logic        misaligned_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    assign byte_v = word_i[{offset_i, 3'b000} +: 8];
    assign half_v = offset_i[1] ? word_i[31:16] : word_i[15:0];

    // Select lane, extend, and flag misalignment; unknown funct3 passes the word
    always_comb begin
        data_o       = word_i;
        misaligned_o = 1'b0;
        case (funct3_i)
            F3_LB:  data_o = {{24{byte_v[7]}}, byte_v};
            F3_LBU: data_o = {24'b0, byte_v};
            F3_LH: begin
                data_o       = {{16{half_v[15]}}, half_v};
                misaligned_o = offset_i[0];
            end
            F3_LHU: begin
                data_o       = {16'b0, half_v};
                misaligned_o = offset_i[0];
            end
            F3_LW:  misaligned_o = |offset_i;
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register, result select and retire counter.
// Outputs depend only on registered state.
module mem_wb_stage
    import wb_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int CNT_WIDTH     = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     stall_w,
    input  logic                     flush_w,
    input  logic                     valid_m,
    input  logic                     reg_write_m,
    input  logic [1:0]               result_src_m,
    input  logic [2:0]               funct3_m,
    input  logic [DATA_WIDTH-1:0]    alu_result_m,
    input  logic [DATA_WIDTH-1:0]    read_data_m,
    input  logic [DATA_WIDTH-1:0]    csr_rdata_m,
    input  logic [ADDRESS_WIDTH-1:0] pc_plus4_m,
    input  logic [4:0]               rd_m,
    output logic [DATA_WIDTH-1:0]    result_w,
    output logic                     reg_write_w,
    output logic [4:0]               rd_w,
    output logic                     valid_w,
    output logic                     load_misaligned_w,
    output logic [CNT_WIDTH-1:0]     instret
);

    logic                     valid_q;
    logic                     reg_write_q;
    logic [1:0]               result_src_q;
    logic [2:0]               funct3_q;
    logic [DATA_WIDTH-1:0]    alu_result_q;
    logic [DATA_WIDTH-1:0]    read_data_q;
    logic [DATA_WIDTH-1:0]    csr_rdata_q;
    logic [ADDRESS_WIDTH-1:0] pc_plus4_q;
    logic [4:0]               rd_q;
    logic [CNT_WIDTH-1:0]     instret_q;
    logic [CNT_WIDTH-1:0]     instret_d;

    logic [31:0] load_data;
    logic        load_mis;
    logic        mis;

    // Pipeline register: flush inserts a bubble, stall holds, else capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q      <= 1'b0;
            reg_write_q  <= 1'b0;
            result_src_q <= '0;
            funct3_q     <= '0;
            alu_result_q <= '0;
            read_data_q  <= '0;
            csr_rdata_q  <= '0;
            pc_plus4_q   <= '0;
            rd_q         <= '0;
        end else if (flush_w) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
        end else if (!stall_w) begin
            valid_q      <= valid_m;
            reg_write_q  <= reg_write_m;
            result_src_q <= result_src_m;
            funct3_q     <= funct3_m;
            alu_result_q <= alu_result_m;
            read_data_q  <= read_data_m;
            csr_rdata_q  <= csr_rdata_m;
            pc_plus4_q   <= pc_plus4_m;
            rd_q         <= rd_m;
        end
    end

    load_ext u_load_ext (
        .word_i       (read_data_q),
        .offset_i     (alu_result_q[1:0]),
        .funct3_i     (funct3_q),
        .data_o       (load_data),
        .misaligned_o (load_mis)
    );

    assign mis = valid_q && (result_src_q == RES_LOAD) && load_mis;

    // Four-way writeback result select
    always_comb begin
        result_w = alu_result_q;
        case (result_src_q)
            RES_LOAD: result_w = load_data;
            RES_PC4:  result_w = DATA_WIDTH'(pc_plus4_q);
            RES_CSR:  result_w = csr_rdata_q;
            default:  ;
        endcase
    end

    assign valid_w           = valid_q;
    assign rd_w              = rd_q;
    assign load_misaligned_w = mis;
    assign reg_write_w       = valid_q && reg_write_q && (rd_q != 5'd0) && !mis;

    // Count an instruction when it leaves WB; a faulting load does not retire
    always_comb begin
        instret_d = instret_q;
        if (valid_q && !stall_w && !mis) begin
            instret_d = instret_q + CNT_WIDTH'(1);
        end
    end

    // Retire counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instret_q <= '0;
        end else begin
            instret_q <= instret_d;
        end
    end

    assign instret = instret_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: vector table,
// corner sequences and a random run against a behavioural model.
module tb_mem_wb_stage;

    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          stall_w, flush_w, valid_m, reg_write_m;
    logic [1:0]    result_src_m;
    logic [2:0]    funct3_m;
    logic [31:0]   alu_result_m, read_data_m, csr_rdata_m, pc_plus4_m;
    logic [4:0]    rd_m;
    logic [31:0]   result_w;
    logic          reg_write_w, valid_w, load_misaligned_w;
    logic [4:0]    rd_w;
    logic [CW-1:0] instret;

    int checks = 0;
    int failures = 0;

    mem_wb_stage #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .stall_w(stall_w), .flush_w(flush_w),
        .valid_m(valid_m), .reg_write_m(reg_write_m),
        .result_src_m(result_src_m), .funct3_m(funct3_m),
        .alu_result_m(alu_result_m), .read_data_m(read_data_m),
        .csr_rdata_m(csr_rdata_m), .pc_plus4_m(pc_plus4_m), .rd_m(rd_m),
        .result_w(result_w), .reg_write_w(reg_write_w), .rd_w(rd_w),
        .valid_w(valid_w), .load_misaligned_w(load_misaligned_w),
        .instret(instret)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic        rw;
        logic [1:0]  src;
        logic [2:0]  f3;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [31:0] csr;
        logic [31:0] pc4;
        logic [4:0]  rd;
    } in_t;

    typedef struct {
        in_t         in;
        logic [31:0] res;
        logic        rw;
        logic [4:0]  rd;
        logic        mis;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic in_t mk_in(logic v, logic rw, logic [1:0] src, logic [2:0] f3,
                                  logic [31:0] alu, logic [31:0] rdata, logic [31:0] csr,
                                  logic [31:0] pc4, logic [4:0] rd);
        in_t x;
        x.valid = v; x.rw = rw; x.src = src; x.f3 = f3; x.alu = alu;
        x.rdata = rdata; x.csr = csr; x.pc4 = pc4; x.rd = rd;
        return x;
    endfunction

    function automatic vec_t mk_vec(in_t x, logic [31:0] res, logic rw, logic [4:0] rd, logic mis);
        vec_t v;
        v.in = x; v.res = res; v.rw = rw; v.rd = rd; v.mis = mis;
        return v;
    endfunction

    task automatic drive(input in_t x);
        valid_m = x.valid; reg_write_m = x.rw; result_src_m = x.src;
        funct3_m = x.f3; alu_result_m = x.alu; read_data_m = x.rdata;
        csr_rdata_m = x.csr; pc_plus4_m = x.pc4; rd_m = x.rd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        stall_w = 1'b0; flush_w = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    // Behavioural reference: load value from address arithmetic
    function automatic logic [31:0] m_load(in_t s);
        int off = int'(s.alu % 4);
        longint b = (longint'(s.rdata) >> (8 * off)) & 255;
        longint h = (longint'(s.rdata) >> (16 * (off / 2))) & 65535;
        case (s.f3)
            3'd0: return 32'(b >= 128 ? b - 256 : b);
            3'd4: return 32'(b);
            3'd1: return 32'(h >= 32768 ? h - 65536 : h);
            3'd5: return 32'(h);
            default: return s.rdata;
        endcase
    endfunction

    function automatic logic m_mis(in_t s);
        int sz;
        if (!s.valid || s.src != 2'd1) return 1'b0;
        case (s.f3)
            3'd1, 3'd5: sz = 2;
            3'd2: sz = 4;
            default: sz = 1;
        endcase
        return (s.alu % sz) != 0;
    endfunction

    function automatic logic [31:0] m_res(in_t s);
        case (s.src)
            2'd0: return s.alu;
            2'd1: return m_load(s);
            2'd2: return s.pc4;
            default: return s.csr;
        endcase
    endfunction

    localparam logic [31:0] W = 32'h80F1_7F22;
    vec_t tbl[13];
    in_t  slot, cur, bub;
    logic [CW-1:0] m_cnt;

    initial begin
        rst = 1'b1;
        stall_w = 1'b0; flush_w = 1'b0;
        bub = mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(bub);
        #1;
        chk("reset_valid", valid_w, 0);
        chk("reset_result", result_w, 0);
        chk("reset_instret", instret, 0);
        do_reset();

        // Misaligned LW does not retire
        drive(mk_in(1, 1, 1, 3'd2, 32'h1002, W, 0, 0, 5'd6));
        tick();
        chk("lw_mis_flag", load_misaligned_w, 1);
        chk("lw_mis_rw", reg_write_w, 0);
        drive(bub);
        tick();
        chk("lw_mis_instret", instret, 0);

        tbl[0]  = mk_vec(mk_in(1, 1, 1, 3'd0, 32'h1003, W, 0, 0, 5), 32'hFFFF_FF80, 1, 5, 0);
        tbl[1]  = mk_vec(mk_in(1, 1, 1, 3'd4, 32'h1002, W, 0, 0, 5), 32'h0000_00F1, 1, 5, 0);
        tbl[2]  = mk_vec(mk_in(1, 1, 1, 3'd1, 32'h1002, W, 0, 0, 5), 32'hFFFF_80F1, 1, 5, 0);
        tbl[3]  = mk_vec(mk_in(1, 1, 1, 3'd5, 32'h1002, W, 0, 0, 5), 32'h0000_80F1, 1, 5, 0);
        tbl[4]  = mk_vec(mk_in(1, 1, 1, 3'd2, 32'h1002, W, 0, 0, 5), W, 0, 5, 1);
        tbl[5]  = mk_vec(mk_in(1, 1, 1, 3'd1, 32'h1001, W, 0, 0, 5), 32'h0000_7F22, 0, 5, 1);
        tbl[6]  = mk_vec(mk_in(1, 1, 0, 3'd0, 32'h5, 0, 0, 0, 0), 32'h5, 0, 0, 0);
        tbl[7]  = mk_vec(mk_in(1, 1, 0, 3'd0, 32'h5, 0, 0, 0, 3), 32'h5, 1, 3, 0);
        tbl[8]  = mk_vec(mk_in(1, 1, 3, 3'd0, 32'h0, 0, 32'hDEAD_BEEF, 0, 7), 32'hDEAD_BEEF, 1, 7, 0);
        tbl[9]  = mk_vec(mk_in(1, 1, 2, 3'd0, 32'h0, 0, 0, 32'h104, 1), 32'h104, 1, 1, 0);
        tbl[10] = mk_vec(mk_in(1, 1, 1, 3'd0, 32'h1001, W, 0, 0, 9), 32'h0000_007F, 1, 9, 0);
        tbl[11] = mk_vec(mk_in(1, 1, 1, 3'd3, 32'h1003, W, 0, 0, 9), W, 1, 9, 0);
        tbl[12] = mk_vec(mk_in(0, 1, 0, 3'd0, 32'h9, 0, 0, 0, 4), 32'h9, 0, 4, 0);

        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].in);
            tick();
            chk($sformatf("tbl%0d_result", i), result_w, tbl[i].res);
            chk($sformatf("tbl%0d_rw", i), reg_write_w, tbl[i].rw);
            chk($sformatf("tbl%0d_rd", i), rd_w, tbl[i].rd);
            chk($sformatf("tbl%0d_mis", i), load_misaligned_w, tbl[i].mis);
        end

        // JAL held in WB across a 3-cycle stall
        do_reset();
        drive(mk_in(1, 1, 2, 3'd0, 32'h0, 0, 0, 32'h104, 1));
        tick();
        chk("jal_result", result_w, 32'h104);
        stall_w = 1'b1;
        drive(bub);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("stall%0d_result", i), result_w, 32'h104);
            chk($sformatf("stall%0d_instret", i), instret, 0);
        end
        stall_w = 1'b0;
        tick();
        chk("unstall_instret", instret, 1);
        chk("unstall_valid", valid_w, 0);

        // Flush beats stall
        drive(mk_in(1, 1, 0, 3'd0, 32'h11, 0, 0, 0, 2));
        tick();
        chk("pre_flush_rw", reg_write_w, 1);
        flush_w = 1'b1; stall_w = 1'b1;
        tick();
        chk("flush_stall_valid", valid_w, 0);
        chk("flush_stall_rw", reg_write_w, 0);
        chk("flush_stall_instret", instret, 1);
        flush_w = 1'b0; stall_w = 1'b0;

        // Counter wrap
        do_reset();
        drive(mk_in(1, 1, 0, 3'd0, 32'h1, 0, 0, 0, 1));
        for (int i = 0; i < 256; i++) tick();
        chk("wrap_max", instret, 8'hFF);
        flush_w = 1'b1;
        tick();
        chk("wrap_zero", instret, 0);
        chk("wrap_flush_valid", valid_w, 0);
        flush_w = 1'b0;

        // Random traffic against the model
        do_reset();
        slot = bub;
        m_cnt = '0;
        for (int n = 0; n < 400; n++) begin
            cur.valid = 1'($urandom_range(0, 3) != 0);
            cur.rw    = 1'($urandom_range(0, 3) != 0);
            cur.src   = 2'($urandom);
            case ($urandom_range(0, 6))
                0: cur.f3 = 3'd0; 1: cur.f3 = 3'd1; 2: cur.f3 = 3'd2;
                3: cur.f3 = 3'd4; 4: cur.f3 = 3'd5; 5: cur.f3 = 3'd3;
                default: cur.f3 = 3'd6;
            endcase
            cur.alu   = $urandom;
            cur.rdata = $urandom;
            cur.csr   = $urandom;
            cur.pc4   = $urandom;
            cur.rd    = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
            stall_w   = ($urandom_range(0, 4) == 0);
            flush_w   = ($urandom_range(0, 7) == 0);
            drive(cur);
            @(posedge clk);
            if (slot.valid && !stall_w && !m_mis(slot)) m_cnt = m_cnt + 1'b1;
            if (flush_w) begin
                slot.valid = 1'b0;
                slot.rw = 1'b0;
            end else if (!stall_w) begin
                slot = cur;
            end
            #1;
            chk("rnd_valid", valid_w, slot.valid);
            chk("rnd_mis", load_misaligned_w, m_mis(slot));
            chk("rnd_rw", reg_write_w,
                slot.valid && slot.rw && slot.rd != 0 && !m_mis(slot));
            chk("rnd_instret", instret, m_cnt);
            if (slot.valid) begin
                chk("rnd_result", result_w, m_res(slot));
                chk("rnd_rd", rd_w, slot.rd);
            end
        end

        // Asynchronous reset mid-run
        stall_w = 1'b1; flush_w = 1'b0;
        drive(mk_in(1, 1, 2, 3'd0, 32'h0, 0, 0, 32'h104, 1));
        stall_w = 1'b0;
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk("async_valid", valid_w, 0);
        chk("async_rw", reg_write_w, 0);
        chk("async_rd", rd_w, 0);
        chk("async_result", result_w, 0);
        chk("async_mis", load_misaligned_w, 0);
        chk("async_instret", instret, 0);
        tick();
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
